voice_req_enc: RTL and testbench

Sequential 8-to-3 request encoder for the eight PCM voice channels. It is the inverse of the one-hot channel-select decoder. It collects active-low service requests from the voices, picks one, and presents it to the shared sequencer as a binary channel index. It also returns the matching active-low one-hot grant. A valid/ack handshake paces the sequencer; requests that arrive while an offer is outstanding are held pending and are never lost.

---
 rtl/voice_req_enc.sv | 134 +++++++++++++
 tb/tb_voice_req_enc.sv | 265 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/voice_req_enc.sv
// Sequential 8-to-3 request encoder: latches active-low voice requests and offers one
// channel at a time over a valid/ack handshake. Define VOICE_REQ_RR_EN for round-robin selection.
module voice_req_enc (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] req_n,
    input  logic       enable,
    input  logic       ack,
    output logic       valid,
    output logic [2:0] index,
    output logic [7:0] grant_n,
    output logic [7:0] pending
);

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_OFFER = 1'b1
    } state_t;

    state_t     state_r;
    state_t     state_s;
    logic [7:0] pending_r;
    logic [7:0] pending_s;
    logic [7:0] clr_s;
    logic       valid_r;
    logic       valid_s;
    logic [2:0] index_r;
    logic [2:0] index_s;
    logic [7:0] grant_n_r;
    logic [7:0] grant_n_s;
    logic [2:0] winner_s;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'd1 << idx;
    endfunction

    // First set bit of vec scanning upward from start, wrapping 7 -> 0.
    function automatic logic [2:0] first_from(input logic [7:0] vec, input logic [2:0] start);
        logic [2:0] pos;
        logic       found;
        first_from = 3'd0;
        found      = 1'b0;
        for (int i = 0; i < 8; i++) begin
            pos = start + i[2:0];
            if (!found && vec[pos]) begin
                first_from = pos;
                found      = 1'b1;
            end
        end
    endfunction

`ifdef VOICE_REQ_RR_EN
    logic [2:0] ptr_r;
    logic [2:0] ptr_s;

    assign winner_s = first_from(pending_r, ptr_r);
`else
    assign winner_s = first_from(pending_r, 3'd0);
`endif

    // Next-state, offer outputs and pending update; a request held low through its ack re-sets its bit.
    always_comb begin
        state_s   = state_r;
        valid_s   = valid_r;
        index_s   = index_r;
        grant_n_s = grant_n_r;
        clr_s     = 8'h00;
`ifdef VOICE_REQ_RR_EN
        ptr_s     = ptr_r;
`endif
        case (state_r)
            ST_IDLE: begin
                if (enable && (pending_r != 8'h00)) begin
                    state_s   = ST_OFFER;
                    valid_s   = 1'b1;
                    index_s   = winner_s;
                    grant_n_s = ~onehot8(winner_s);
                end else begin
                    valid_s   = 1'b0;
                    grant_n_s = 8'hFF;
                end
            end
            ST_OFFER: begin
                if (ack) begin
                    clr_s     = onehot8(index_r);
`ifdef VOICE_REQ_RR_EN
                    ptr_s     = index_r + 3'd1;
`endif
                    valid_s   = 1'b0;
                    grant_n_s = 8'hFF;
                    state_s   = ST_IDLE;
                end else begin
                    valid_s   = 1'b1;
                    grant_n_s = grant_n_r;
                end
            end
            default: begin
                state_s   = ST_IDLE;
                valid_s   = 1'b0;
                grant_n_s = 8'hFF;
            end
        endcase
        pending_s = (pending_r & ~clr_s) | ~req_n;
    end

    // State, pending and registered offer outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r   <= ST_IDLE;
            pending_r <= 8'h00;
            valid_r   <= 1'b0;
            index_r   <= 3'd0;
            grant_n_r <= 8'hFF;
`ifdef VOICE_REQ_RR_EN
            ptr_r     <= 3'd0;
`endif
        end else begin
            state_r   <= state_s;
            pending_r <= pending_s;
            valid_r   <= valid_s;
            index_r   <= index_s;
            grant_n_r <= grant_n_s;
`ifdef VOICE_REQ_RR_EN
            ptr_r     <= ptr_s;
`endif
        end
    end

    assign valid   = valid_r;
    assign index   = index_r;
    assign grant_n = grant_n_r;
    assign pending = pending_r;

endmodule

// File: tb/tb_voice_req_enc.sv
// Self-checking bench for voice_req_enc: cycle vector table plus a scoreboard of expected offers.
module tb_voice_req_enc;

    logic       clk = 1'b0;
    logic       reset;
    logic [7:0] req_n;
    logic       enable;
    logic       ack;
    logic       valid;
    logic [2:0] index;
    logic [7:0] grant_n;
    logic [7:0] pending;

    voice_req_enc dut (
        .clk     (clk),
        .reset   (reset),
        .req_n   (req_n),
        .enable  (enable),
        .ack     (ack),
        .valid   (valid),
        .index   (index),
        .grant_n (grant_n),
        .pending (pending)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    typedef struct {
        logic       rst;
        logic [7:0] req_n;
        logic       en;
        logic       ack;
        logic       e_valid;
        logic [2:0] e_index;
        logic       chk_index;
        logic [7:0] e_grant_n;
        logic [7:0] e_pending;
    } vec_t;

    vec_t vq[$];
    int   exp_q[$];

    logic       mon_on = 1'b0;
    logic       spacing_on = 1'b0;
    logic       prev_valid = 1'b0;
    int         last_cyc = -1;
    int         mon_e;
    logic [7:0] mon_g;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic addv(input logic rst, input logic [7:0] rq, input logic en, input logic ak,
                        input logic ev, input logic [2:0] ei, input logic ci,
                        input logic [7:0] eg, input logic [7:0] ep);
        vec_t v;
        v.rst = rst; v.req_n = rq; v.en = en; v.ack = ak;
        v.e_valid = ev; v.e_index = ei; v.chk_index = ci; v.e_grant_n = eg; v.e_pending = ep;
        vq.push_back(v);
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        ack    = 1'b0;
        req_n  = 8'hFF;
        enable = 1'b1;
        tick();
        reset  = 1'b0;
    endtask

    task automatic pulse_req(input logic [7:0] rq);
        req_n = rq;
        tick();
        req_n = 8'hFF;
    endtask

    task automatic wait_drain(input string name, input int max);
        for (int i = 0; i < max && exp_q.size() != 0; i++) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_timeout remaining=%0d expected=0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: each rising valid must match the next expected channel.
    always @(negedge clk) begin
        if (mon_on && valid && !prev_valid) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_offer actual=%0d expected=none", index);
            end else begin
                mon_e = exp_q.pop_front();
                mon_g = ~(8'd1 << mon_e);
                chk("offer_index", int'(index), mon_e);
                chk("offer_grant_n", int'(grant_n), int'(mon_g));
                if (spacing_on && last_cyc >= 0) chk("offer_spacing", cyc - last_cyc, 2);
                last_cyc = cyc;
            end
        end
        prev_valid = valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset  = 1'b1;
        req_n  = 8'hFF;
        enable = 1'b1;
        ack    = 1'b0;

        // single request, hold for 5 cycles, ack, ack ignored in idle
        addv(1'b1, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF, 8'h00);
        addv(1'b0, 8'hF7, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h08);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hF7, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd3, 1'b1, 8'hF7, 8'h08);
        addv(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h00);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h00);
        addv(1'b0, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h00);
        // enable low blocks, enable high offers, reset with ack drops the offer
        addv(1'b0, 8'hEF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h10);
        addv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h10);
        addv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h10);
        addv(1'b0, 8'hFF, 1'b0, 1'b0, 1'b0, 3'd0, 1'b0, 8'hFF, 8'h10);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b1, 3'd4, 1'b1, 8'hEF, 8'h10);
        addv(1'b1, 8'hFF, 1'b1, 1'b1, 1'b0, 3'd0, 1'b1, 8'hFF, 8'h00);
        addv(1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 3'd0, 1'b1, 8'hFF, 8'h00);

        for (int i = 0; i < vq.size(); i++) begin
            reset  = vq[i].rst;
            req_n  = vq[i].req_n;
            enable = vq[i].en;
            ack    = vq[i].ack;
            tick();
            chk($sformatf("vec%0d_valid", i), int'(valid), int'(vq[i].e_valid));
            if (vq[i].chk_index) chk($sformatf("vec%0d_index", i), int'(index), int'(vq[i].e_index));
            chk($sformatf("vec%0d_grant_n", i), int'(grant_n), int'(vq[i].e_grant_n));
            chk($sformatf("vec%0d_pending", i), int'(pending), int'(vq[i].e_pending));
        end

        mon_on = 1'b1;

        // all requests at once, ack tied high: one grant every 2 cycles
        do_reset();
        ack = 1'b1;
        for (int c = 0; c < 8; c++) exp_q.push_back(c);
        last_cyc   = -1;
        spacing_on = 1'b1;
        pulse_req(8'h00);
        wait_drain("all_req", 40);
        spacing_on = 1'b0;
        for (int c = 0; c < 4; c++) begin
            tick();
            chk("all_req_idle_valid", int'(valid), 0);
        end
        chk("all_req_pending", int'(pending), 0);
        ack = 1'b0;

        // wrap-around after granting channel 6
        do_reset();
        exp_q.push_back(6);
        pulse_req(8'hBF);
        wait_drain("wrap_first", 10);
        ack = 1'b1;
        tick();
        ack = 1'b0;
`ifdef VOICE_REQ_RR_EN
        exp_q.push_back(7);
        exp_q.push_back(1);
`else
        exp_q.push_back(1);
        exp_q.push_back(7);
`endif
        pulse_req(8'h7D);
        ack = 1'b1;
        wait_drain("wrap_pair", 20);
        ack = 1'b0;

        // request held through its own ack is offered again after the bubble
        do_reset();
        req_n = 8'hFB;
        exp_q.push_back(2);
        wait_drain("held_first", 10);
        ack = 1'b1;
        exp_q.push_back(2);
        tick();
        ack = 1'b0;
        chk("held_bubble_valid", int'(valid), 0);
        chk("held_pending", int'(pending), 8'h04);
        tick();
        chk("held_reoffer_valid", int'(valid), 1);
        chk("held_reoffer_index", int'(index), 2);
        req_n = 8'hFF;
        ack   = 1'b1;
        tick();
        ack   = 1'b0;
        tick();
        chk("held_final_pending", int'(pending), 0);
        chk("held_final_valid", int'(valid), 0);
        wait_drain("held_reoffer", 4);

        // pending 8'h84 after a grant of channel 2 (pointer at 3)
        do_reset();
        exp_q.push_back(2);
        pulse_req(8'hFB);
        wait_drain("p3_setup", 10);
        ack = 1'b1;
        tick();
        ack = 1'b0;
`ifdef VOICE_REQ_RR_EN
        exp_q.push_back(7);
        exp_q.push_back(2);
`else
        exp_q.push_back(2);
        exp_q.push_back(7);
`endif
        pulse_req(8'h7B);
        ack = 1'b1;
        wait_drain("p3_pair", 20);
        ack = 1'b0;

        // pending 8'h84 straight out of reset (pointer at 0)
        do_reset();
        exp_q.push_back(2);
        exp_q.push_back(7);
        pulse_req(8'h7B);
        ack = 1'b1;
        wait_drain("p0_pair", 20);
        ack = 1'b0;
        tick();
        tick();
        chk("end_valid", int'(valid), 0);
        chk("end_grant_n", int'(grant_n), 8'hFF);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
